// File: rtl/gsensor_spi_seq.sv
// ADXL345 SPI sequencer (mode 3): config writes after reset, then periodic XYZ burst reads.
// Define GSENSOR_DEVID_CHECK_EN to add a DEVID (0xE5) check frame and the id_error output.
module gsensor_spi_seq #(
  parameter int         CLK_DIV         = 25,
  parameter int         SAMPLE_PERIOD   = 250000,
  parameter logic [7:0] DATA_FORMAT_VAL = 8'h0B,
  parameter logic [7:0] POWER_CTL_VAL   = 8'h08
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out,
  output logic signed [15:0] z_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               init_done
`ifdef GSENSOR_DEVID_CHECK_EN
  ,
  output logic               id_error
`endif
);

  localparam int GAP   = 2 * CLK_DIV;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP);
  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    RST_GAP, CFG_FMT, CFG_PWR, WAIT, RD_XYZ, UPDATE
`ifdef GSENSOR_DEVID_CHECK_EN
    , CHK_ID, ERR
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [6:0]         half_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [PER_W-1:0]   per_cnt;
  logic               long_frm, rearm;
  logic [55:0]        tx, start_tx;
  logic [47:0]        rx;
  logic               start, start_long, rd_start;
  logic               tick, frame_end, fall_ev, rise_ev, gap_ok, per_done;

  // Sensor sends each axis low byte first.
  function automatic logic signed [15:0] le_word(input logic [15:0] b);
    return {b[7:0], b[15:8]};
  endfunction

  // Half-period sequencing: half_cnt counts completed SCLK half-periods since cs_n fell.
  assign tick      = ~cs_n && (div_cnt == DIV_LAST);
  assign frame_end = tick && (half_cnt == (long_frm ? 7'd112 : 7'd32));
  assign fall_ev   = tick && !frame_end && !half_cnt[0];
  assign rise_ev   = tick && half_cnt[0];
  assign gap_ok    = cs_n && (gap_cnt == GAP_LAST);
  assign per_done  = (per_cnt == PER_LAST);
  assign rd_start  = start && start_long;

  assign busy         = ~cs_n;
  assign sample_valid = (state == UPDATE);

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    start_long = 1'b0;
    start_tx   = '0;
    case (state)
`ifdef GSENSOR_DEVID_CHECK_EN
      RST_GAP: if (gap_ok) state_nxt = CHK_ID;
      CHK_ID:  if (frame_end) state_nxt = (rx[7:0] == 8'hE5) ? CFG_FMT : ERR;
      ERR:     state_nxt = ERR;
`else
      RST_GAP: if (gap_ok) state_nxt = CFG_FMT;
`endif
      CFG_FMT: if (frame_end) state_nxt = CFG_PWR;
      CFG_PWR: if (frame_end) state_nxt = WAIT;
      WAIT:    if (enable && (per_done || rearm) && gap_ok) state_nxt = RD_XYZ;
      RD_XYZ:  if (frame_end) state_nxt = UPDATE;
      UPDATE:  state_nxt = WAIT;
      default: state_nxt = RST_GAP;
    endcase
    // A frame state with cs_n high has not launched its frame yet.
    if (gap_ok) begin
      case (state_nxt)
`ifdef GSENSOR_DEVID_CHECK_EN
        CHK_ID:  begin start = 1'b1; start_tx = {8'h80, 8'h00, 40'd0}; end
`endif
        CFG_FMT: begin start = 1'b1; start_tx = {8'h31, DATA_FORMAT_VAL, 40'd0}; end
        CFG_PWR: begin start = 1'b1; start_tx = {8'h2D, POWER_CTL_VAL, 40'd0}; end
        RD_XYZ:  begin start = 1'b1; start_long = 1'b1; start_tx = {8'hF2, 48'd0}; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_GAP;
      cs_n      <= 1'b1;
      sclk      <= 1'b1;
      mosi      <= 1'b0;
      div_cnt   <= '0;
      half_cnt  <= '0;
      long_frm  <= 1'b0;
      gap_cnt   <= '0;
      per_cnt   <= '0;
      rearm     <= 1'b1;
      init_done <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
`ifdef GSENSOR_DEVID_CHECK_EN
      id_error  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (start) begin
        cs_n     <= 1'b0;
        div_cnt  <= '0;
        half_cnt <= '0;
        long_frm <= start_long;
      end else if (tick) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 7'd1;
        if (frame_end) begin
          cs_n <= 1'b1;
          mosi <= 1'b0;
        end else if (fall_ev) begin
          sclk <= 1'b0;
          mosi <= tx[55];
        end else begin
          sclk <= 1'b1;
        end
      end else if (~cs_n) begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (~cs_n)                 gap_cnt <= '0;
      else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;

      if (rd_start)              per_cnt <= '0;
      else if (!per_done)        per_cnt <= per_cnt + 1'b1;

      if (rd_start)              rearm <= 1'b0;
      else if (!enable)          rearm <= 1'b1;

      if (state == CFG_PWR && frame_end) init_done <= 1'b1;
      if (state == RD_XYZ && frame_end) begin
        x_out <= le_word(rx[47:32]);
        y_out <= le_word(rx[31:16]);
        z_out <= le_word(rx[15:0]);
      end
`ifdef GSENSOR_DEVID_CHECK_EN
      if (state == CHK_ID && frame_end && rx[7:0] != 8'hE5) id_error <= 1'b1;
`endif
    end
  end

  // Shift registers carry no control meaning, so they are left out of reset.
  always_ff @(posedge clk) begin
    if (start)        tx <= start_tx;
    else if (fall_ev) tx <= {tx[54:0], 1'b0};
    if (rise_ev)      rx <= {rx[46:0], miso};
  end

endmodule

// File: tb/tb_gsensor_spi_seq.sv
// Scoreboard bench for gsensor_spi_seq: SPI slave model, frame/timing monitor, XYZ sample checks.
// With +define+GSENSOR_DEVID_CHECK_EN the DEVID-mismatch path is exercised first.
`timescale 1ns/1ps
module tb_gsensor_spi_seq;
  localparam int CD = 4;
  localparam int SP = 2000;
`ifdef GSENSOR_DEVID_CHECK_EN
  localparam int N_CFG = 3;
`else
  localparam int N_CFG = 2;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, miso = 1'b0;
  logic sclk, cs_n, mosi, sample_valid, busy, init_done;
  logic [15:0] x_out, y_out, z_out;
  logic sclk_b, cs_n_b, mosi_b, sv_b, busy_b, idn_b;
  logic [15:0] x_b, y_b, z_b;
`ifdef GSENSOR_DEVID_CHECK_EN
  logic id_error, id_error_b;
`endif

  always #5 clk = ~clk;

  gsensor_spi_seq #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .x_out(x_out), .y_out(y_out), .z_out(z_out), .sample_valid(sample_valid),
    .busy(busy), .init_done(init_done)
`ifdef GSENSOR_DEVID_CHECK_EN
    , .id_error(id_error)
`endif
  );

  gsensor_spi_seq #(.CLK_DIV(CD), .SAMPLE_PERIOD(10)) dut_b2b (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b),
    .miso(1'b0), .x_out(x_b), .y_out(y_b), .z_out(z_b), .sample_valid(sv_b),
    .busy(busy_b), .init_done(idn_b)
`ifdef GSENSOR_DEVID_CHECK_EN
    , .id_error(id_error_b)
`endif
  );

  int n_vec = 0, n_miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard queues: frames as {bit count, first 16 mosi bits}; samples as {x,y,z}.
  logic [23:0] exp_frm[$];
  logic [47:0] exp_smp[$];

  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_sv = 1'b0;
  logic [55:0] mosi_sr = '0;
  logic [7:0]  rbytes [6];
  logic [7:0]  dev_id = 8'hE5;
  logic [15:0] last_x = '0, last_y = '0, last_z = '0;
  int nbits = 0, rsp_kind = 0, frm_start = 0, last_rise = 0, last_fall = -1;
  int cs_rise_cyc = 0, per_min = 0, per_max = 0, fcount = 0, smp_count = 0, rd_count = 0;
  int last_rd_start = 0, rd_idx = 0;
  bit have_rise = 0, last_rd_valid = 0, en_low_seen = 0, pend_ok = 0;

  task automatic pick_resp();
    logic [31:0] r0, r1;
    if (rd_idx == 0) begin
      rbytes[0] = 8'h34; rbytes[1] = 8'h12; rbytes[2] = 8'h78;
      rbytes[3] = 8'h56; rbytes[4] = 8'hBC; rbytes[5] = 8'h9A;
    end else if (rd_idx == 1) begin
      rbytes[0] = 8'h00; rbytes[1] = 8'h80; rbytes[2] = 8'hFF;
      rbytes[3] = 8'h7F; rbytes[4] = 8'h01; rbytes[5] = 8'h80;
    end else begin
      r0 = $urandom; r1 = $urandom;
      rbytes[0] = r0[7:0];   rbytes[1] = r0[15:8]; rbytes[2] = r0[23:16];
      rbytes[3] = r0[31:24]; rbytes[4] = r1[7:0];  rbytes[5] = r1[15:8];
    end
    rd_idx++;
    exp_smp.push_back({rbytes[1], rbytes[0], rbytes[3], rbytes[2], rbytes[5], rbytes[4]});
  endtask

  // Slave model and monitor for the main instance, all sampled on the falling clk edge.
  always @(negedge clk) begin
    logic [23:0] got, e;
    logic [47:0] s;
    int d;
    if (!rst_n) begin
      exp_smp.delete();
      nbits = 0; fcount = 0; rsp_kind = 0; have_rise = 0; last_rd_valid = 0; en_low_seen = 0;
      last_x = '0; last_y = '0; last_z = '0; miso = 1'b0;
    end else begin
      if (prev_sv) chk("sv_pulse", sample_valid, 1'b0);
      if (sample_valid) begin
        chk("smp_avail", 64'(exp_smp.size() != 0), 1);
        if (exp_smp.size() != 0) begin
          s = exp_smp.pop_front();
          chk("x_out", x_out, s[47:32]);
          chk("y_out", y_out, s[31:16]);
          chk("z_out", z_out, s[15:0]);
          last_x = s[47:32]; last_y = s[31:16]; last_z = s[15:0];
        end
        smp_count++;
      end
      if (prev_cs && !cs_n) begin
        if (have_rise) chk("cs_gap_min", 64'((cyc - cs_rise_cyc) >= 2 * CD), 1);
        chk("busy_lo", busy, 1'b1);
        chk("hold_xyz", {x_out, y_out, z_out}, {last_x, last_y, last_z});
        frm_start = cyc; nbits = 0; mosi_sr = '0; last_fall = -1; rsp_kind = 0;
        per_min = 1000000; per_max = 0;
        pend_ok = !en_low_seen; en_low_seen = 0;
      end
      if (!cs_n && prev_sclk && !sclk) begin
        if (last_fall < 0) chk("lead", 64'(cyc - frm_start), CD);
        else begin
          d = cyc - last_fall;
          if (d < per_min) per_min = d;
          if (d > per_max) per_max = d;
        end
        last_fall = cyc;
        if (rsp_kind == 1 && nbits >= 8 && nbits < 56) miso = rbytes[(nbits - 8) / 8][7 - ((nbits - 8) % 8)];
        else if (rsp_kind == 2 && nbits >= 8 && nbits < 16) miso = dev_id[7 - (nbits - 8)];
        else miso = 1'b0;
      end
      if (!cs_n && !prev_sclk && sclk) begin
        mosi_sr = {mosi_sr[54:0], mosi};
        nbits++;
        last_rise = cyc;
        if (nbits == 8) begin
          if (mosi_sr[7:0] == 8'hF2) begin rsp_kind = 1; pick_resp(); end
          else if (mosi_sr[7:0] == 8'h80) rsp_kind = 2;
        end
      end
      if (!prev_cs && cs_n) begin
        fcount++;
        cs_rise_cyc = cyc; have_rise = 1; miso = 1'b0;
        chk("busy_hi", busy, 1'b0);
        chk("cs_hold", 64'(cyc - last_rise), CD);
        chk("sclk_per_min", 64'(per_min), 2 * CD);
        chk("sclk_per_max", 64'(per_max), 2 * CD);
        got = {8'(nbits), (nbits >= 16) ? 16'(mosi_sr >> (nbits - 16)) : 16'h0000};
        e = (exp_frm.size() != 0) ? exp_frm.pop_front() : {8'd56, 16'hF200};
        chk("frame", got, e);
        chk("init_done", init_done, 64'(fcount >= N_CFG));
        if (nbits == 56) begin
          rd_count++;
          if (last_rd_valid && pend_ok) chk("period", 64'(frm_start - last_rd_start), SP);
          last_rd_start = frm_start; last_rd_valid = 1;
        end
      end
    end
    en_low_seen = en_low_seen | !enable;
    prev_cs = cs_n; prev_sclk = sclk; prev_sv = sample_valid;
  end

  // Back-to-back instance: every cs_n-high gap must be exactly the minimum.
  logic b_prev_cs = 1'b1;
  int b_rise = 0, b_cnt = 0;
  bit b_have = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      b_have = 0; b_cnt = 0;
    end else begin
`ifndef GSENSOR_DEVID_CHECK_EN
      if (b_prev_cs && !cs_n_b && b_have && b_cnt < 8) chk("b2b_gap", 64'(cyc - b_rise), 2 * CD);
`endif
      if (!b_prev_cs && cs_n_b) begin b_rise = cyc; b_have = 1; b_cnt++; end
    end
    b_prev_cs = cs_n_b;
  end

  task automatic wait_samples(input int n, input int budget);
    int tgt;
    int k;
    tgt = smp_count + n; k = 0;
    while (smp_count < tgt && k < budget) begin @(negedge clk); k++; end
    chk("samples_in_time", 64'(smp_count >= tgt), 1);
  endtask

  task automatic wait_rd_bits(input int n, input int budget);
    int k;
    k = 0;
    while (!(rsp_kind == 1 && !cs_n && nbits >= n) && k < budget) begin @(negedge clk); k++; end
    chk("reach_rd_bit", 64'(rsp_kind == 1 && !cs_n && nbits >= n), 1);
  endtask

  task automatic push_cfg();
`ifdef GSENSOR_DEVID_CHECK_EN
    exp_frm.push_back({8'd16, 16'h8000});
`endif
    exp_frm.push_back({8'd16, 16'h310B});
    exp_frm.push_back({8'd16, 16'h2D08});
  endtask

  initial begin
    int n0, r0, c_en, k;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_xyz", {x_out, y_out, z_out}, 48'd0);
    chk("rst_sv", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
`ifdef GSENSOR_DEVID_CHECK_EN
    chk("rst_id_error", id_error, 1'b0);
    dev_id = 8'hE4;
    exp_frm.push_back({8'd16, 16'h8000});
    rst_n = 1'b1;
    repeat (1500) @(negedge clk);
    chk("id_error_set", id_error, 1'b1);
    chk("err_init_done", init_done, 1'b0);
    chk("err_frames", 64'(fcount), 1);
    chk("err_cs_n", cs_n, 1'b1);
    chk("err_sclk", sclk, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    dev_id = 8'hE5;
`endif
    enable = 1'b1;
    push_cfg();
    rst_n = 1'b1;
    wait_samples(4, 10000);
`ifdef GSENSOR_DEVID_CHECK_EN
    chk("id_ok", id_error, 1'b0);
`endif

    // Drop enable mid read: frame completes, one sample, then parked.
    wait_rd_bits(20, 3000);
    enable = 1'b0;
    n0 = smp_count; r0 = rd_count;
    repeat (2500) @(negedge clk);
    chk("drop_one_sample", 64'(smp_count - n0), 1);
    chk("drop_one_frame", 64'(rd_count - r0), 1);
    chk("parked_cs_n", cs_n, 1'b1);
    enable = 1'b1;
    c_en = cyc; k = 0;
    do begin @(negedge clk); k++; end while (cs_n && k < 50);
    chk("reen_start", 64'(cyc), 64'(c_en + 1));
    wait_samples(2, 6000);

    // Asynchronous reset in the middle of a read frame.
    wait_rd_bits(30, 3000);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 1'b1);
    chk("mid_rst_sclk", sclk, 1'b1);
    chk("mid_rst_mosi", mosi, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_xyz", {x_out, y_out, z_out}, 48'd0);
    chk("mid_rst_init", init_done, 1'b0);
    chk("mid_rst_sv", sample_valid, 1'b0);
    repeat (2) @(negedge clk);
    push_cfg();
    rst_n = 1'b1;
    wait_samples(1, 4000);
    chk("cfg_queue_drained", 64'(exp_frm.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not complete (vectors %0d)", n_vec);
    $fatal(1, "watchdog");
  end

endmodule
